// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential fetch, branch/flush
// redirect, and a one-deep buffer for a branch resolved while fetch is stalled.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                INC       = 4,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               pend_valid,
  output logic               misaligned
);

  localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pc_nxt, pend_target_nxt;
  logic              pend_valid_nxt;

  // Only the PC-stage bit matters; the rest exist for a uniform pipeline hookup.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:1];

  always_comb begin
    pc_nxt          = pc;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    if (ce) begin
      if (flush) begin
        pc_nxt         = new_pc;
        pend_valid_nxt = 1'b0;
      end else if (stall[0]) begin
        if (branch_flag) begin
          pend_target_nxt = branch_target;
          pend_valid_nxt  = 1'b1;
        end
      end else if (branch_flag) begin
        pc_nxt         = branch_target;
        pend_valid_nxt = 1'b0;
      end else if (pend_valid) begin
        pc_nxt         = pend_target;
        pend_valid_nxt = 1'b0;
      end else begin
        pc_nxt = pc + INC_V;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce          <= 1'b0;
      pc          <= RESET_VEC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      ce          <= 1'b1;
      pc          <= pc_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  assign misaligned = (pc % INC_V) != '0;

endmodule
